// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Front-end input stage for the display/timer datapath. Brings the raw start
//   button and slide switches into the clk domain, debounces them, and hands
//   clean control signals to the mode/counter logic.
//
// Ports
//   clk           system clock (only clock)
//   reset         asynchronous, active-low reset (0 = reset)
//   signal_start  raw bouncing start button (1 = pressed)
//   sw            raw slide switches [SW_WIDTH]
//   start_pulse   one-cycle registered pulse per accepted press
//   isActive      run/stop level, toggles on each accepted press
//   sw_stable     debounced switch value [SW_WIDTH]
//   sw_changed    one-cycle registered pulse when sw_stable updates
//   btn_state     debug: current button FSM state (IDLE=0, PRESS_WAIT=1,
//                 PRESSED=2, RELEASE_WAIT=3)
//
// Handshake: none. All outputs are plain registered levels/pulses; consumers
// sample them on any clk edge with no ready/valid back-pressure.
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                signal_start,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                start_pulse,
  output logic                isActive,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                sw_changed,
  output logic [1:0]          btn_state
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2(N)) bits suffice.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers; only the second stage is used downstream.
  // ---------------------------------------------------------------------------
  logic                btn_meta, btn_s;
  logic [SW_WIDTH-1:0] sw_meta, sw_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= signal_start;
      btn_s    <= btn_meta;
      sw_meta  <= sw;
      sw_s     <= sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Button debounce FSM
  // ---------------------------------------------------------------------------
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] bcnt, bcnt_next;
  logic             pulse_next, active_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bcnt        <= '0;
      start_pulse <= 1'b0;
      isActive    <= 1'b0;
    end else begin
      state       <= state_next;
      bcnt        <= bcnt_next;
      start_pulse <= pulse_next;
      isActive    <= active_next;
    end
  end

  always_comb begin
    state_next  = state;
    bcnt_next   = bcnt;
    pulse_next  = 1'b0;
    active_next = isActive;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          bcnt_next  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          bcnt_next  = '0;
        end else if (bcnt == CNT_LAST) begin
          // Press accepted: the pulse and the toggle are registered together.
          state_next  = PRESSED;
          bcnt_next   = '0;
          pulse_next  = 1'b1;
          active_next = ~isActive;
        end else begin
          bcnt_next = bcnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          bcnt_next  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: back to held, never a second pulse.
          state_next = PRESSED;
          bcnt_next  = '0;
        end else if (bcnt == CNT_LAST) begin
          state_next = IDLE;
          bcnt_next  = '0;
        end else begin
          bcnt_next = bcnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = '0;
      end
    endcase
  end

  assign btn_state = state;

  // ---------------------------------------------------------------------------
  // Switch debounce: one candidate and one counter for the whole bus, so a
  // toggle on any bit restarts the wait for every bit.
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_cand;
  logic [CNT_W-1:0]    scnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_cand    <= '0;
      sw_stable  <= '0;
      sw_changed <= 1'b0;
      scnt       <= '0;
    end else begin
      sw_changed <= 1'b0;
      if (sw_s != sw_cand) begin
        sw_cand <= sw_s;
        scnt    <= '0;
      end else if (sw_cand != sw_stable) begin
        if (scnt == CNT_LAST) begin
          sw_stable  <= sw_cand;
          sw_changed <= 1'b1;
          scnt       <= '0;
        end else begin
          scnt <= scnt + CNT_W'(1);
        end
      end else begin
        scnt <= '0;
      end
    end
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end input stage for the Lab 6 display/timer datapath. It takes the raw start push-button and the 10 slide switches and synchronizes each into `clk`. It debounces them and produces three outputs for the downstream mode/counter logic: a clean one-cycle start pulse, a run/stop level (`isActive`), and a stable switch bus. It replaces direct use of raw pad signals by the `modes` stage.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000, cycles an input must hold a new level before it is accepted (10 ms at 100 MHz). Legal minimum is 2.
- `SW_WIDTH`, default 10, width of the switch bus.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `signal_start`  in  1  raw, bouncing start button (1 = pressed).
- `sw`  in  SW_WIDTH  raw slide switches.
- `start_pulse`  out  1  one-cycle pulse per accepted press.
- `isActive`  out  1  run/stop level; toggles on each accepted press.
- `sw_stable`  out  SW_WIDTH  debounced switch value.
- `sw_changed`  out  1  one-cycle pulse when `sw_stable` updates.

## Operation
- **Synchronizers:** every raw input passes through a 2-flop synchronizer. Only the second flop (`btn_s`, `sw_s`) is used downstream.
- **Button FSM** (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) with counter `bcnt`, width ceil(log2(DEBOUNCE_CYCLES)):
  - IDLE: if `btn_s`=1, go to PRESS_WAIT with `bcnt`=0.
  - PRESS_WAIT: if `btn_s`=0, go to IDLE. Else if `bcnt`==DEBOUNCE_CYCLES-1, go to PRESSED, register `start_pulse`=1 for one cycle and invert `isActive`. Else increment `bcnt`.
  - PRESSED: hold while `btn_s`=1. If `btn_s`=0, go to RELEASE_WAIT with `bcnt`=0. No pulse is generated while held.
  - RELEASE_WAIT: if `btn_s`=1, go back to PRESSED (bounce on release, no new pulse). Else if `bcnt`==DEBOUNCE_CYCLES-1, go to IDLE. Else increment `bcnt`.
- **Switch debounce:** the whole bus shares one candidate register `sw_cand` and one counter `scnt`.
  - If `sw_s` != `sw_cand`: load `sw_cand` <= `sw_s`, clear `scnt`.
  - Else if `sw_cand` != `sw_stable`: if `scnt`==DEBOUNCE_CYCLES-1, load `sw_stable` <= `sw_cand`, pulse `sw_changed` for one cycle, clear `scnt`; otherwise increment `scnt`.
  - Else hold `scnt` at 0.
  - Any bit toggling during the wait restarts the wait for the whole bus.
- **Counters** never wrap. Each counter is cleared on every state entry and saturates by transition.
- **Button and switch paths are independent.** Simultaneous events on both paths are each processed in the same cycle.

## Timing
- **Reset** (asynchronous, while `reset`=0): synchronizers, `sw_cand`, and `sw_stable` = 0; `start_pulse`=0, `isActive`=0, `sw_changed`=0; FSM = IDLE; `bcnt` = `scnt` = 0. Release is sampled synchronously at the next `clk` edge.
- **Reset mid-operation:** state is discarded immediately. The FSM does not auto-resume.
- **Press latency:** if raw `signal_start` rises and is first captured at edge k and stays high, `start_pulse` and the new `isActive` appear after edge k+2+DEBOUNCE_CYCLES.
- **Switch latency:** if `sw` changes at edge k and holds, `sw_stable` and `sw_changed` update after edge k+2+DEBOUNCE_CYCLES.
- **Minimum hold:** a level held in `btn_s` for fewer than DEBOUNCE_CYCLES cycles is rejected.
- **Pulse width:** `start_pulse` and `sw_changed` are exactly one cycle wide and registered (glitch-free).
- **Reset held at power-up with `sw` ≠ 0:** after release, `sw_stable` reaches `sw` after the normal switch latency, with one `sw_changed` pulse.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SW_WIDTH=10.
- **Clean press:** reset low 3 cycles then high; `signal_start`=1 held 20 cycles -> exactly one `start_pulse`, 6 cycles after first capture. `isActive` goes 0->1 on that cycle and stays 1 after release.
- **Bouncy press:** `signal_start` pattern 1,0,1,1,0,1 then steady 1 -> one `start_pulse` only, 6 cycles after the start of the steady-1 run. Release bounces 0,1,0 then steady 0 produce no pulse. A second clean press returns `isActive` to 0.
- **Short glitch:** `signal_start`=1 for 3 cycles then 0 -> no `start_pulse`; `isActive` stays 0.
- **Switch change:** `sw` 0x000 -> 0x2A5 held -> `sw_stable`=0x2A5 and one `sw_changed` pulse 6 cycles later.
- **Switch bounce:** `sw` 0x2A5 -> 0x3FF for 2 cycles -> 0x000 held -> `sw_stable` never shows 0x3FF, goes to 0x000 6 cycles after the final change, single pulse.
- **Reset mid-press:** assert reset while the FSM is in PRESS_WAIT with `isActive`=1 -> all outputs 0 immediately. After release with `signal_start` still held, one pulse follows after full latency and `isActive`=1.
